// File: rtl/cpu_trace_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_trace_pkg: record kinds, FSM states and the trace record      |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
package cpu_trace_pkg;

  // Widest instruction number a record can carry; CNT_W must not exceed it.
  localparam int INUM_W = 32;

  localparam logic [1:0] KIND_OTHER = 2'd0;
  localparam logic [1:0] KIND_REG   = 2'd1;
  localparam logic [1:0] KIND_LOAD  = 2'd2;
  localparam logic [1:0] KIND_STORE = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [1:0]        kind;
    logic              halt;
    logic [INUM_W-1:0] inum;
    logic [15:0]       pc;
    logic [3:0]        regn;
    logic [15:0]       val;
    logic [15:0]       addr;
  } trace_rec_t;

endpackage
`default_nettype wire

// File: rtl/commit_trace_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | commit_trace_unit_if: commit bus in, trace record handshake out   |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
interface commit_trace_unit_if #(
  parameter int CNT_W = 32
);
  logic             wb_valid;
  logic [15:0]      wb_pc;
  logic [15:0]      wb_inst;
  logic             wb_regwrite;
  logic [3:0]       wb_dstreg;
  logic [15:0]      wb_dstdata;
  logic             wb_memread;
  logic             wb_memwrite;
  logic [15:0]      wb_memaddr;
  logic [15:0]      wb_memdata;
  logic             wb_halt;

  logic             tr_valid;
  logic             tr_ready;
  logic [1:0]       tr_kind;
  logic             tr_halt;
  logic [CNT_W-1:0] tr_inum;
  logic [15:0]      tr_pc;
  logic [3:0]       tr_reg;
  logic [15:0]      tr_val;
  logic [15:0]      tr_addr;

  // Trace unit side
  modport slave (
    input  wb_valid, wb_pc, wb_inst, wb_regwrite, wb_dstreg, wb_dstdata,
           wb_memread, wb_memwrite, wb_memaddr, wb_memdata, wb_halt,
    input  tr_ready,
    output tr_valid, tr_kind, tr_halt, tr_inum, tr_pc, tr_reg, tr_val, tr_addr
  );

  // CPU / consumer side
  modport master (
    output wb_valid, wb_pc, wb_inst, wb_regwrite, wb_dstreg, wb_dstdata,
           wb_memread, wb_memwrite, wb_memaddr, wb_memdata, wb_halt,
    output tr_ready,
    input  tr_valid, tr_kind, tr_halt, tr_inum, tr_pc, tr_reg, tr_val, tr_addr
  );
endinterface
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trace_fifo: synchronous FIFO of trace records, DEPTH power of two |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
import cpu_trace_pkg::*;

module trace_fifo #(
  parameter int DEPTH = 8
) (
  input  wire         clk,
  input  wire         rst_n,
  input  wire         i_push,
  input  trace_rec_t  i_data,
  input  wire         i_pop,
  output trace_rec_t  o_data,
  output logic        o_full,
  output logic        o_empty
);

  localparam int              C_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [C_AW:0]   C_FULL = (C_AW + 1)'(DEPTH);

  trace_rec_t       r_mem [DEPTH];
  trace_rec_t       r_last;
  logic [C_AW-1:0]  r_wr_ptr;
  logic [C_AW-1:0]  r_rd_ptr;
  logic [C_AW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == C_FULL);
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = i_push & (~o_full | w_pop);

  // When empty the output holds the last record that left the FIFO.
  assign o_data  = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/commit_trace_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | commit_trace_unit: classifies, numbers and buffers retired insts; |
// | optional cycle-limit watchdog under COMMIT_WATCHDOG_EN.           |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
import cpu_trace_pkg::*;

module commit_trace_unit #(
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  wire                 clk,
  input  wire                 rst_n,
  commit_trace_unit_if.slave  trc,
  output logic [CNT_W-1:0]    inst_count,
  output logic [CNT_W-1:0]    cycle_count,
  output logic                halted,
  output logic                overflow,
  output logic                timeout
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1 || CNT_W > INUM_W ||
      MAX_CYCLES < 1) begin : g_param_err
    $error("commit_trace_unit: illegal parameter set");
  end

  trace_state_t      r_state;
  logic              r_halted;
  logic              r_timeout;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_inst_count;
  logic [CNT_W-1:0]  r_cycle_count;
  logic              r_stage_vld;
  trace_rec_t        r_stage_rec;

  logic              w_accept;
  logic              w_in_run;
  logic [CNT_W-1:0]  w_cyc_next;
  logic              w_wd_hit;
  trace_rec_t        w_rec;
  trace_rec_t        w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;
  logic              w_drop;
  logic              w_unused;

  // The instruction word travels on the commit bus but is not traced.
  assign w_unused = ^trc.wb_inst;

  assign w_in_run   = (r_state == ST_RUN);
  assign w_accept   = trc.wb_valid & w_in_run;
  assign w_cyc_next = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;

`ifdef COMMIT_WATCHDOG_EN
  localparam logic [CNT_W-1:0] C_WD_LIMIT = CNT_W'(MAX_CYCLES);
  assign w_wd_hit = (w_cyc_next >= C_WD_LIMIT);
`else
  assign w_wd_hit = 1'b0;
`endif

  always_comb begin
    w_rec      = '0;
    w_rec.halt = trc.wb_halt;
    w_rec.inum = INUM_W'(r_inst_count);
    w_rec.pc   = trc.wb_pc;
    if (trc.wb_regwrite && trc.wb_memread) begin
      w_rec.kind = KIND_LOAD;
      w_rec.regn = trc.wb_dstreg;
      w_rec.val  = trc.wb_dstdata;
      w_rec.addr = trc.wb_memaddr;
    end else if (trc.wb_regwrite) begin
      w_rec.kind = KIND_REG;
      w_rec.regn = trc.wb_dstreg;
      w_rec.val  = trc.wb_dstdata;
    end else if (trc.wb_memwrite) begin
      w_rec.kind = KIND_STORE;
      w_rec.val  = trc.wb_memdata;
      w_rec.addr = trc.wb_memaddr;
    end else begin
      w_rec.kind = KIND_OTHER;
    end
  end

  // Input stage: the record enters the FIFO one edge after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage_vld <= 1'b0;
      r_stage_rec <= '0;
    end else begin
      r_stage_vld <= w_accept;
      if (w_accept) begin
        r_stage_rec <= w_rec;
      end
    end
  end

  assign w_pop  = ~w_fifo_empty & trc.tr_ready;
  assign w_drop = r_stage_vld & w_fifo_full & ~w_pop;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_stage_vld),
    .i_data  (r_stage_rec),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inst_count  <= '0;
      r_cycle_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_accept && !(&r_inst_count)) begin
        r_inst_count <= r_inst_count + 1'b1;
      end
      if (w_in_run) begin
        r_cycle_count <= w_cyc_next;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // A halt commit in the same cycle as the watchdog limit takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept && trc.wb_halt) begin
            r_state <= ST_DRAIN;
          end else if (w_wd_hit) begin
            r_state   <= ST_TIMEOUT;
            r_timeout <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_fifo_empty && !r_stage_vld && !w_pop) begin
            r_state  <= ST_DONE;
            r_halted <= 1'b1;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign trc.tr_valid = ~w_fifo_empty;
  assign trc.tr_kind  = w_head.kind;
  assign trc.tr_halt  = w_head.halt;
  assign trc.tr_inum  = w_head.inum[CNT_W-1:0];
  assign trc.tr_pc    = w_head.pc;
  assign trc.tr_reg   = w_head.regn;
  assign trc.tr_val   = w_head.val;
  assign trc.tr_addr  = w_head.addr;

  assign inst_count  = r_inst_count;
  assign cycle_count = r_cycle_count;
  assign halted      = r_halted;
  assign overflow    = r_overflow;
  assign timeout     = r_timeout;

endmodule
`default_nettype wire
